// File: rtl/lzc16_seq_pkg.sv
// Shared definitions for the sequential 16-bit leading-zero counter:
// FSM state codes and operand, nibble and count widths.
package lzc16_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIN_W = 16;
  localparam int NIB_W = 4;
  localparam int CNT_W = 5;

endpackage

// File: rtl/lzc16_seq_lzc4.sv
// Combinational leading-zero count of one nibble (0..3).
// An all-zero nibble returns 3; the caller only uses s when x is nonzero.
module lzc4
  import lzc16_seq_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  output logic [1:0]       s
);

  always_comb begin
    s = 2'd3;
    casez (x)
      4'b1???: s = 2'd0;
      4'b01??: s = 2'd1;
      4'b001?: s = 2'd2;
      default: s = 2'd3;
    endcase
  end

endmodule

// File: rtl/lzc16_seq.sv
// Sequential leading-zero counter: scans one nibble per cycle from the MSB,
// then pulses done for one cycle with count, zero flag and normalised operand.
module lzc16_seq
  import lzc16_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIN_W-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic [DIN_W-1:0] norm
);

  logic [1:0]       r_state;
  logic [DIN_W-1:0] r_work;
  logic [CNT_W-1:0] r_acc;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_zero;
  logic [DIN_W-1:0] r_norm;

  logic [NIB_W-1:0] w_top;
  logic [1:0]       w_lz;
  logic             w_hit;
  logic [CNT_W-1:0] w_acc_nxt;
  logic [DIN_W-1:0] w_work_nxt;

  assign w_top = r_work[DIN_W-1:DIN_W-NIB_W];
  assign w_hit = |w_top;

  lzc4 u_lzc4 (
    .x (w_top),
    .s (w_lz)
  );

  // Accumulator tops out at 4*4 = 16, which fits the 5-bit count without wrap.
  assign w_acc_nxt  = w_hit ? (r_acc + {3'b000, w_lz}) : (r_acc + CNT_W'(NIB_W));
  assign w_work_nxt = w_hit ? (r_work << w_lz) : (r_work << NIB_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
      r_norm  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work  <= din;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_acc  <= w_acc_nxt;
          r_work <= w_work_nxt;
          if (!w_hit) begin
            r_idx <= r_idx + 2'd1;
          end
          if (w_hit || (r_idx == 2'd3)) begin
            r_count <= w_acc_nxt;
            r_norm  <= w_work_nxt;
            r_zero  <= !w_hit;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_DONE);
  assign count = r_count;
  assign zero  = r_zero;
  assign norm  = r_norm;

endmodule
